// File: rtl/insertion_sort.sv
// Sequential insertion sort over a packed array: one compare per cycle, stable.
// Define INSERTION_SORT_DESCENDING_EN to sort descending (element 0 = maximum).
module insertion_sort #(
  parameter int SIZE_DATA = 8,
  parameter int NUM_VALS  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [NUM_VALS*SIZE_DATA-1:0] i_data,
  output logic                          o_done,
  output logic [NUM_VALS*SIZE_DATA-1:0] o_data,
  output logic [1:0]                    dbg_state
);

  localparam int IW = $clog2(NUM_VALS) + 1;
  localparam int AW = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1;
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [IW-1:0] N_IW = IW'(NUM_VALS);

  // Start handshake: i_start is a request sampled on a rising edge; it is
  // accepted only in IDLE or DONE, and i_data is captured on that same edge.
  typedef enum logic [1:0] {IDLE, PICK, SCAN, DONE} state_t;

  state_t               state, state_next;
  logic [SIZE_DATA-1:0] arr   [NUM_VALS];
  logic [SIZE_DATA-1:0] arr_n [NUM_VALS];
  logic [SIZE_DATA-1:0] key;
  logic [IW-1:0]        i, j;
  logic [IW-1:0]        i_inc, j_p1;
  logic [AW-1:0]        i_a, j_a, jp1_a;
  logic                 gt, load, place, out_load;

  assign dbg_state = state;
  assign i_inc     = i + ONE;
  assign j_p1      = j + ONE;
  assign i_a       = i[AW-1:0];
  assign j_a       = j[AW-1:0];
  assign jp1_a     = j_p1[AW-1:0];

`ifdef INSERTION_SORT_DESCENDING_EN
  assign gt = (arr[j_a] < key);
`else
  assign gt = (arr[j_a] > key);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    place      = 1'b0;
    out_load   = 1'b0;
    for (int k = 0; k < NUM_VALS; k++) arr_n[k] = arr[k];
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          load = 1'b1;
          for (int k = 0; k < NUM_VALS; k++) arr_n[k] = i_data[k*SIZE_DATA +: SIZE_DATA];
          state_next = (NUM_VALS == 1) ? DONE : PICK;
          out_load   = (NUM_VALS == 1);
        end
      end
      PICK: state_next = SCAN;
      SCAN: begin
        // Strict compare keeps equal keys in input order; at j=0 the shift
        // and the key placement share one cycle so j never wraps.
        if (gt) begin
          arr_n[jp1_a] = arr[j_a];
          if (j == '0) arr_n[0] = key;
        end else begin
          arr_n[jp1_a] = key;
        end
        if (!gt || j == '0) begin
          place      = 1'b1;
          state_next = (i_inc == N_IW) ? DONE : PICK;
          out_load   = (i_inc == N_IW);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_VALS; k++) arr[k] <= '0;
      key    <= '0;
      i      <= '0;
      j      <= '0;
      o_done <= 1'b0;
      o_data <= '0;
    end else begin
      for (int k = 0; k < NUM_VALS; k++) arr[k] <= arr_n[k];
      if (load) begin
        i      <= ONE;
        j      <= '0;
        o_done <= 1'b0;
      end
      if (state == PICK) begin
        key <= arr[i_a];
        j   <= i - ONE;
      end
      if (state == SCAN) begin
        if (place) i <= i_inc;
        else       j <= j - ONE;
      end
      // Output register includes this cycle's final write.
      if (out_load) begin
        o_done <= 1'b1;
        for (int k = 0; k < NUM_VALS; k++) o_data[k*SIZE_DATA +: SIZE_DATA] <= arr_n[k];
      end
    end
  end

endmodule

// File: tb/tb_insertion_sort.sv
// Scenario bench for insertion_sort: reset, fixed vectors, latency, restart
// rules, mid-sort reset and random vectors against a bubble-sort reference.
module tb_insertion_sort;

  localparam int SD = 8;
  localparam int NV = 8;
  localparam int W  = SD * NV;
  localparam int MAX_LAT = NV * (NV + 1) / 2 + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic [W-1:0] i_data;
  logic         o_done;
  logic [W-1:0] o_data;
  logic [1:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  insertion_sort #(.SIZE_DATA(SD), .NUM_VALS(NV)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (i_start),
    .i_data    (i_data),
    .o_done    (o_done),
    .o_data    (o_data),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: stable adjacent-swap bubble sort.
  function automatic logic [W-1:0] model_sort(input logic [W-1:0] d);
    logic [SD-1:0] v [NV];
    logic [SD-1:0] t;
    logic [W-1:0]  r;
    bit            swap;
    for (int k = 0; k < NV; k++) v[k] = d[k*SD +: SD];
    for (int p = 0; p < NV - 1; p++)
      for (int k = 0; k < NV - 1 - p; k++) begin
`ifdef INSERTION_SORT_DESCENDING_EN
        swap = (v[k] < v[k+1]);
`else
        swap = (v[k] > v[k+1]);
`endif
        if (swap) begin t = v[k]; v[k] = v[k+1]; v[k+1] = t; end
      end
    for (int k = 0; k < NV; k++) r[k*SD +: SD] = v[k];
    return r;
  endfunction

  function automatic logic [W-1:0] pack8(input int e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7[7:0], e6[7:0], e5[7:0], e4[7:0], e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
  endfunction

  // Driver: one-cycle start, then wait for o_done. cycles counts rising
  // edges including the accepting edge; held tracks o_data stability.
  task automatic start_and_wait(input logic [W-1:0] d, output int cycles,
                                output bit timeout, output bit held);
    logic [W-1:0] old;
    @(negedge clk);
    i_data  = d;
    i_start = 1'b1;
    old     = o_data;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    cycles  = 1;
    held    = 1'b1;
    timeout = 1'b0;
    while (!o_done) begin
      if (o_data !== old) held = 1'b0;
      if (cycles >= 200) begin timeout = 1'b1; break; end
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_data  = '0;
    #12;
    checks++;
    if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", o_done); end
    checks++;
    if (o_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", o_data); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_example();
    logic [W-1:0] d, exp;
    int cyc; bit to, held;
    d = pack8(1, 29, 15, 0, 20, 1, 1, 12);
    exp_q.push_back(model_sort(d));
    start_and_wait(d, cyc, to, held);
    exp = exp_q.pop_front();
    checks++;
    if (to || o_data !== exp) begin errors++; $display("FAIL example_data: got %h want %h timeout %0b", o_data, exp, to); end
`ifndef INSERTION_SORT_DESCENDING_EN
    checks++;
    if (o_data !== 64'h1D140F0C01010100) begin errors++; $display("FAIL example_const: got %h want 1d140f0c01010100", o_data); end
`endif
    checks++;
    if (cyc > MAX_LAT) begin errors++; $display("FAIL example_latency: got %0d want <= %0d", cyc, MAX_LAT); end
    checks++;
    if (!held) begin errors++; $display("FAIL example_hold: o_data changed during sort"); end
  endtask

  task automatic test_sorted();
    logic [W-1:0] d, exp;
    int cyc; bit to, held;
`ifdef INSERTION_SORT_DESCENDING_EN
    d = pack8(7, 6, 5, 4, 3, 2, 1, 0);
`else
    d = pack8(0, 1, 2, 3, 4, 5, 6, 7);
`endif
    exp_q.push_back(d);
    start_and_wait(d, cyc, to, held);
    exp = exp_q.pop_front();
    checks++;
    if (to || o_data !== exp) begin errors++; $display("FAIL sorted_data: got %h want %h", o_data, exp); end
    checks++;
    if (cyc != 2 * (NV - 1) + 1) begin errors++; $display("FAIL sorted_latency: got %0d want %0d", cyc, 2 * (NV - 1) + 1); end
  endtask

  task automatic test_reverse();
    logic [W-1:0] d, exp;
    int cyc; bit to, held;
    d = pack8(7, 6, 5, 4, 3, 2, 1, 0);
`ifdef INSERTION_SORT_DESCENDING_EN
    exp_q.push_back(d);
`else
    exp_q.push_back(pack8(0, 1, 2, 3, 4, 5, 6, 7));
`endif
    start_and_wait(d, cyc, to, held);
    exp = exp_q.pop_front();
    checks++;
    if (to || o_data !== exp) begin errors++; $display("FAIL reverse_data: got %h want %h", o_data, exp); end
    checks++;
    if (cyc > MAX_LAT) begin errors++; $display("FAIL reverse_latency: got %0d want <= %0d", cyc, MAX_LAT); end
  endtask

  task automatic test_restart_ignored();
    logic [W-1:0] a, exp;
    int cyc;
    a = pack8(9, 3, 200, 3, 77, 0, 255, 18);
    exp_q.push_back(model_sort(a));
    @(negedge clk);
    i_data = a; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    i_data = pack8(1, 1, 1, 1, 1, 1, 1, 1); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while (!o_done && cyc < 200) begin @(posedge clk); #1; cyc++; end
    exp = exp_q.pop_front();
    checks++;
    if (!o_done || o_data !== exp) begin errors++; $display("FAIL restart_ignored: got %h want %h done %0b", o_data, exp, o_done); end
  endtask

  task automatic test_reset_midsort();
    logic [W-1:0] exp;
    int cyc; bit to, held;
    @(negedge clk);
    i_data = pack8(50, 40, 30, 20, 10, 5, 4, 3); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_done !== 1'b0 || o_data !== '0) begin errors++; $display("FAIL midsort_reset: done %0b data %h want 0 0", o_done, o_data); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL midsort_state: got %0d want 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({W{1'b1}});
    start_and_wait({W{1'b1}}, cyc, to, held);
    exp = exp_q.pop_front();
    checks++;
    if (to || o_done !== 1'b1 || o_data !== exp) begin errors++; $display("FAIL ff_restart: got %h want %h", o_data, exp); end
  endtask

  task automatic test_start_in_done();
    logic [W-1:0] d, exp;
    int cyc; bit to, held;
    d = pack8(4, 8, 2, 6, 1, 3, 5, 7);
    exp_q.push_back(model_sort(d));
    start_and_wait(d, cyc, to, held);
    checks++;
    if (cyc < 2) begin errors++; $display("FAIL done_drop: o_done stayed high, cycles %0d want >= 2", cyc); end
    checks++;
    if (!held) begin errors++; $display("FAIL done_hold: old o_data not held before new result"); end
    exp = exp_q.pop_front();
    checks++;
    if (to || o_data !== exp) begin errors++; $display("FAIL done_restart_data: got %h want %h", o_data, exp); end
  endtask

  task automatic test_random();
    logic [W-1:0] d, exp;
    int cyc; bit to, held;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < NV; k++) d[k*SD +: SD] = SD'($urandom_range(0, (n < 4) ? 15 : 255));
      exp_q.push_back(model_sort(d));
      start_and_wait(d, cyc, to, held);
      exp = exp_q.pop_front();
      checks++;
      if (to || o_data !== exp) begin errors++; $display("FAIL random_%0d: got %h want %h", n, o_data, exp); end
      checks++;
      if (cyc > MAX_LAT) begin errors++; $display("FAIL random_lat_%0d: got %0d want <= %0d", n, cyc, MAX_LAT); end
    end
  endtask

  initial begin
    test_reset();
    test_example();
    test_sorted();
    test_reverse();
    test_restart_ignored();
    test_reset_midsort();
    test_start_in_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
